pl_irq_collector: RTL and testbench

Interrupt collection stage sitting directly downstream of the PL periodic interrupt generator and upstream of the PS interrupt input. It turns the generator's short pulses (3 ms and 0.5 ms ticks, 1 µs wide) into per-source sticky pending bits. It drives a single level interrupt to the PS and accepts a masked acknowledge from software. It counts missed (overrun) ticks per source so software can detect service latency problems.

---
 rtl/pl_irq_collector.sv | 103 ++++++++++
 tb/tb_pl_irq_collector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_irq_collector.sv
// pl_irq_collector
//   Collects rising-edge interrupt events from the PL periodic tick generator.
//   It keeps them as sticky pending bits and presents one registered level
//   interrupt plus the lowest enabled pending source ID to the PS. It also
//   counts, per source, ticks that arrived while the previous one was still
//   pending.
//
// Ports
//   Sys_clk     system clock
//   Rst_n       asynchronous active-low reset
//   Irq_src_in  raw tick pulses, one event per rising edge
//   Irq_en      per-source enable mask
//   Ack_valid   acknowledge strobe (one acknowledge per cycle held)
//   Ack_mask    pending bits cleared by the acknowledge
//   Ovr_clr     clears all overrun counters
//   Pending     sticky pending bits
//   Irq_to_ps   registered level interrupt: any enabled bit pending
//   Irq_id      registered index of the lowest enabled pending source
//   Ack_done    one-cycle confirmation of each acknowledge
//   Ovr_cnt     packed saturating overrun counters, source i at [i*OVR_W +: OVR_W]
module pl_irq_collector #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned OVR_W   = 8
) (
  input  logic                     Sys_clk,
  input  logic                     Rst_n,
  input  logic [NUM_SRC-1:0]       Irq_src_in,
  input  logic [NUM_SRC-1:0]       Irq_en,
  input  logic                     Ack_valid,
  input  logic [NUM_SRC-1:0]       Ack_mask,
  input  logic                     Ovr_clr,
  output logic [NUM_SRC-1:0]       Pending,
  output logic                     Irq_to_ps,
  output logic [ID_W-1:0]          Irq_id,
  output logic                     Ack_done,
  output logic [NUM_SRC*OVR_W-1:0] Ovr_cnt
);

  logic [NUM_SRC-1:0]            src_d;
  logic [NUM_SRC-1:0]            rise;
  logic [NUM_SRC-1:0]            ev;
  logic [NUM_SRC-1:0]            clr;
  logic [NUM_SRC-1:0]            pend_q;
  logic [NUM_SRC-1:0]            act;
  logic [NUM_SRC-1:0][OVR_W-1:0] ovr_q;
  logic [ID_W-1:0]               id_nxt;
  logic                          id_found;

  assign rise = Irq_src_in & ~src_d;
  assign ev   = rise & Irq_en;
  assign clr  = {NUM_SRC{Ack_valid}} & Ack_mask;
  assign act  = pend_q & Irq_en;

  assign Pending = pend_q;
  assign Ovr_cnt = ovr_q;

  // Lowest-index enabled pending source wins; 0 when nothing is active.
  always_comb begin
    id_nxt   = '0;
    id_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (act[i] && !id_found) begin
        id_nxt   = ID_W'(i);
        id_found = 1'b1;
      end
    end
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      src_d     <= '0;
      pend_q    <= '0;
      Irq_to_ps <= 1'b0;
      Irq_id    <= '0;
      Ack_done  <= 1'b0;
    end else begin
      src_d     <= Irq_src_in;
      // A new event wins over a simultaneous acknowledge of the same bit.
      pend_q    <= ev | (pend_q & ~clr);
      Irq_to_ps <= |act;
      Irq_id    <= id_nxt;
      Ack_done  <= Ack_valid;
    end
  end

  // An event that meets an acknowledge in the same cycle is not an overrun:
  // the older event was consumed by that acknowledge.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovr_q <= '0;
    end else if (Ovr_clr) begin
      ovr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (ev[i] && pend_q[i] && !clr[i] && (ovr_q[i] != '1)) begin
          ovr_q[i] <= ovr_q[i] + OVR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pl_irq_collector.sv
module tb_pl_irq_collector;

  logic       Sys_clk;
  logic       Rst_n;
  logic [1:0] Irq_src_in;
  logic [1:0] Irq_en;
  logic       Ack_valid;
  logic [1:0] Ack_mask;
  logic       Ovr_clr;
  logic [1:0] Pending;
  logic       Irq_to_ps;
  logic [0:0] Irq_id;
  logic       Ack_done;
  logic [3:0] Ovr_cnt;

  int errors = 0;
  int checks = 0;

  pl_irq_collector #(.NUM_SRC(2), .ID_W(1), .OVR_W(2)) dut (
    .Sys_clk   (Sys_clk),
    .Rst_n     (Rst_n),
    .Irq_src_in(Irq_src_in),
    .Irq_en    (Irq_en),
    .Ack_valid (Ack_valid),
    .Ack_mask  (Ack_mask),
    .Ovr_clr   (Ovr_clr),
    .Pending   (Pending),
    .Irq_to_ps (Irq_to_ps),
    .Irq_id    (Irq_id),
    .Ack_done  (Ack_done),
    .Ovr_cnt   (Ovr_cnt)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic pulse(input int src);
    Irq_src_in[src] = 1'b1;
    step();
    Irq_src_in[src] = 1'b0;
    step();
  endtask

  task automatic ack(input logic [1:0] m);
    Ack_valid = 1'b1;
    Ack_mask  = m;
    step();
    Ack_valid = 1'b0;
    Ack_mask  = 2'b00;
    step();
  endtask

  task automatic test_reset();
    logic bad;
    bad = 1'b0;
    Rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Irq_src_in = 2'($urandom);
      Irq_en     = 2'($urandom);
      Ack_valid  = 1'($urandom);
      Ack_mask   = 2'($urandom);
      Ovr_clr    = 1'($urandom);
      step();
      if ({Pending, Irq_to_ps, Irq_id, Ack_done, Ovr_cnt} !== 9'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_hold: outputs nonzero during reset, last=%b required 0",
               {Pending, Irq_to_ps, Irq_id, Ack_done, Ovr_cnt});
    end
    Irq_src_in = 2'b01;
    Irq_en     = 2'b11;
    Ack_valid  = 1'b0;
    Ack_mask   = 2'b00;
    Ovr_clr    = 1'b0;
    Rst_n      = 1'b1;
    step();
    checks++;
    if (Pending !== 2'b01) begin
      errors++;
      $display("FAIL reset_high_src_pend: Pending=%b required 01", Pending);
    end
    step();
    checks++;
    if (Irq_to_ps !== 1'b1 || Irq_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_high_src_irq: Irq_to_ps=%b Irq_id=%b required 1 0", Irq_to_ps, Irq_id);
    end
    Irq_src_in = 2'b00;
    ack(2'b01);
  endtask

  task automatic test_single_event();
    logic bad;
    bad = 1'b0;
    Irq_en = 2'b11;
    Irq_src_in[0] = 1'b1;
    step();
    checks++;
    if (Pending !== 2'b01 || Irq_to_ps !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: Pending=%b Irq_to_ps=%b required 01 0", Pending, Irq_to_ps);
    end
    step();
    checks++;
    if (Irq_to_ps !== 1'b1 || Irq_id !== 1'b0) begin
      errors++;
      $display("FAIL single_irq: Irq_to_ps=%b Irq_id=%b required 1 0", Irq_to_ps, Irq_id);
    end
    for (int i = 0; i < 198; i++) begin
      step();
      if (Pending !== 2'b01 || Ovr_cnt !== 4'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_hold: Pending=%b Ovr_cnt=%h required 01 0", Pending, Ovr_cnt);
    end
    Irq_src_in[0] = 1'b0;
    step();
    Ack_valid = 1'b1;
    Ack_mask  = 2'b01;
    step();
    checks++;
    if (Pending !== 2'b00 || Ack_done !== 1'b1 || Irq_to_ps !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: Pending=%b Ack_done=%b Irq_to_ps=%b required 00 1 1",
               Pending, Ack_done, Irq_to_ps);
    end
    Ack_valid = 1'b0;
    Ack_mask  = 2'b00;
    step();
    checks++;
    if (Ack_done !== 1'b0 || Irq_to_ps !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_after: Ack_done=%b Irq_to_ps=%b required 0 0", Ack_done, Irq_to_ps);
    end
  endtask

  task automatic test_overrun();
    Irq_en = 2'b11;
    for (int i = 0; i < 3; i++) pulse(1);
    checks++;
    if (Pending !== 2'b10 || Ovr_cnt !== 4'b1000) begin
      errors++;
      $display("FAIL overrun: Pending=%b Ovr_cnt=%b required 10 1000", Pending, Ovr_cnt);
    end
    checks++;
    if (Irq_to_ps !== 1'b1 || Irq_id !== 1'b1) begin
      errors++;
      $display("FAIL overrun_id: Irq_to_ps=%b Irq_id=%b required 1 1", Irq_to_ps, Irq_id);
    end
    // Acknowledge selecting nothing pending still confirms.
    Ack_valid = 1'b1;
    Ack_mask  = 2'b01;
    step();
    checks++;
    if (Ack_done !== 1'b1 || Pending !== 2'b10) begin
      errors++;
      $display("FAIL ack_empty: Ack_done=%b Pending=%b required 1 10", Ack_done, Pending);
    end
    Ack_valid = 1'b0;
    Ack_mask  = 2'b00;
    Ovr_clr   = 1'b1;
    step();
    Ovr_clr   = 1'b0;
    checks++;
    if (Ovr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ovr_clr: Ovr_cnt=%b required 0000", Ovr_cnt);
    end
    ack(2'b10);
  endtask

  task automatic test_ack_and_event();
    Irq_en = 2'b11;
    pulse(0);
    Irq_src_in[0] = 1'b1;
    Ack_valid     = 1'b1;
    Ack_mask      = 2'b01;
    step();
    checks++;
    if (Pending !== 2'b01 || Ovr_cnt !== 4'd0 || Ack_done !== 1'b1) begin
      errors++;
      $display("FAIL ack_and_event: Pending=%b Ovr_cnt=%b Ack_done=%b required 01 0000 1",
               Pending, Ovr_cnt, Ack_done);
    end
    Irq_src_in[0] = 1'b0;
    Ack_valid     = 1'b0;
    Ack_mask      = 2'b00;
    step();
    ack(2'b01);
  endtask

  task automatic test_masking();
    Irq_en = 2'b01;
    pulse(1);
    step();
    checks++;
    if (Pending !== 2'b00 || Irq_to_ps !== 1'b0 || Ovr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mask_disabled: Pending=%b Irq_to_ps=%b Ovr_cnt=%b required 00 0 0000",
               Pending, Irq_to_ps, Ovr_cnt);
    end
    pulse(0);
    Irq_en = 2'b00;
    step();
    checks++;
    if (Irq_to_ps !== 1'b0 || Pending !== 2'b01) begin
      errors++;
      $display("FAIL mask_off: Irq_to_ps=%b Pending=%b required 0 01", Irq_to_ps, Pending);
    end
    Irq_en = 2'b01;
    step();
    checks++;
    if (Irq_to_ps !== 1'b1) begin
      errors++;
      $display("FAIL mask_restore: Irq_to_ps=%b required 1", Irq_to_ps);
    end
    ack(2'b01);
  endtask

  task automatic test_saturation();
    Irq_en = 2'b11;
    for (int i = 0; i < 6; i++) pulse(0);
    checks++;
    if (Ovr_cnt[1:0] !== 2'd3 || Ovr_cnt[3:2] !== 2'd0) begin
      errors++;
      $display("FAIL saturate: Ovr_cnt=%b required 0011", Ovr_cnt);
    end
    Irq_src_in[0] = 1'b1;
    Ovr_clr       = 1'b1;
    step();
    Ovr_clr = 1'b0;
    checks++;
    if (Ovr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_priority: Ovr_cnt=%b required 0000", Ovr_cnt);
    end
    Irq_src_in[0] = 1'b0;
    step();
    Irq_src_in[0] = 1'b1;
    Ack_valid     = 1'b1;
    Ack_mask      = 2'b10;
    step();
    step();
    checks++;
    if (Ovr_cnt[1:0] !== 2'd1 || Pending !== 2'b01 || Irq_to_ps !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: Ovr_cnt=%b Pending=%b Irq_to_ps=%b required 0001 01 1",
               Ovr_cnt, Pending, Irq_to_ps);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Pending, Irq_to_ps, Irq_id, Ack_done, Ovr_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: outputs=%b required 0", {Pending, Irq_to_ps, Irq_id, Ack_done, Ovr_cnt});
    end
    Ack_valid  = 1'b0;
    Ack_mask   = 2'b00;
    Irq_src_in = 2'b00;
    step();
    Rst_n = 1'b1;
    step();
  endtask

  initial begin
    Rst_n      = 1'b0;
    Irq_src_in = 2'b00;
    Irq_en     = 2'b00;
    Ack_valid  = 1'b0;
    Ack_mask   = 2'b00;
    Ovr_clr    = 1'b0;
    test_reset();
    test_single_event();
    test_overrun();
    test_ack_and_event();
    test_masking();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
